contador_modn_cascata: RTL and testbench

Parametrised cascaded down-counter for the countdown timer path. It generalises the single-digit mod-6 counter to DIGITS digits, each with its own modulus. Each digit rolls over to its modulus minus one on a borrow, so MM:SS-style counts chain inside one block. Adds load saturation, selectable stop-at-zero or wrap mode, a borrow-out for external chaining, and a one-shot done pulse for the buzzer/door logic.

---
 rtl/contador_modn_cascata.sv | 130 +++++++++++++
 tb/tb_contador_modn_cascata.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/contador_modn_cascata.sv
// Cascaded mod-N down-counter: DIGITS digits, each with its own modulus,
// chained through a borrow ripple so MM:SS-style counts live in one block.
// Adds load saturation, stop-at-zero / wrap selection, a borrow-out for
// external chaining and one-shot done / load_err pulses.

// Single digit: loads (with saturation) or decrements on an incoming borrow.
module contador_modn_digit #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] MOD  = 4'd10
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             sat,
  output logic             nxt_zero
);
  localparam logic [WIDTH-1:0] MAX = MOD - WIDTH'(1);

  logic [WIDTH-1:0] digit_q, digit_d;

  assign sat  = (din >= MOD);
  assign zero = (digit_q == '0);

  // Next digit value: load (saturated) beats borrow, borrow beats hold.
  always_comb begin
    digit_d = digit_q;
    if (load)           digit_d = sat ? MAX : din;
    else if (borrow_in) digit_d = zero ? MAX : digit_q - WIDTH'(1);
  end

  assign nxt_zero = (digit_d == '0);
  assign q        = digit_q;

  // Digit register, cleared asynchronously.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) digit_q <= '0;
    else        digit_q <= digit_d;
  end
endmodule

module contador_modn_cascata #(
  parameter int                        DIGITS       = 2,
  parameter int                        WIDTH        = 4,
  parameter logic [DIGITS*WIDTH-1:0]   MODS         = 8'h6A,
  parameter int                        STOP_AT_ZERO = 1
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] data,
  input  logic                    enable,
  output logic [DIGITS*WIDTH-1:0] count,
  output logic [DIGITS-1:0]       digit_tc,
  output logic                    tc,
  output logic                    borrow_out,
  output logic                    done,
  output logic                    load_err
);
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("contador_modn_cascata: DIGITS must be 1..8");
  end

  logic [DIGITS-1:0][WIDTH-1:0] cnt;
  logic [DIGITS-1:0]            borrow;
  logic [DIGITS-1:0]            sat;
  logic [DIGITS-1:0]            nxt_zero;
  logic                         step;
  logic                         done_q, done_d;
  logic                         load_err_q, load_err_d;

  assign tc         = &digit_tc;
  assign borrow_out = enable & tc & ~load;

  // At all-zero, stop mode suppresses the step; wrap mode lets the borrow
  // ripple through every zero digit, which reloads each one to its max.
  assign step      = enable & ~load & (~tc | (STOP_AT_ZERO == 0));
  assign borrow[0] = step;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (int'(MODS[i*WIDTH +: WIDTH]) < 2) begin : g_bad_mod
      $error("contador_modn_cascata: each digit modulus must be >= 2");
    end

    contador_modn_digit #(
      .WIDTH (WIDTH),
      .MOD   (MODS[i*WIDTH +: WIDTH])
    ) u_digit (
      .clk       (clk),
      .clear     (clear),
      .load      (load),
      .din       (data[i*WIDTH +: WIDTH]),
      .borrow_in (borrow[i]),
      .q         (cnt[i]),
      .zero      (digit_tc[i]),
      .sat       (sat[i]),
      .nxt_zero  (nxt_zero[i])
    );

    if (i < DIGITS - 1) begin : g_chain
      assign borrow[i+1] = borrow[i] & digit_tc[i];
    end
  end

  assign count = cnt;

  // Pulse sources: done only on a real decrement that lands on zero,
  // load_err only on a load that had to clamp some digit.
  always_comb begin
    done_d     = step & ~tc & (&nxt_zero);
    load_err_d = load & (|sat);
  end

  // Pulse registers; recomputed every edge so they never hold.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign done     = done_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_contador_modn_cascata.sv
// Directed bench: default stop-mode counter, a wrap-mode copy and a
// three-digit copy, each checked against hand-computed values.
module tb_contador_modn_cascata;
  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // stop-at-zero, default MM:SS-style 2 digits
  logic       ld_a = 0, en_a = 0;
  logic [7:0] dat_a = '0, cnt_a;
  logic [1:0] dtc_a;
  logic       tc_a, bo_a, dn_a, le_a;

  // wrap mode
  logic       ld_w = 0, en_w = 0;
  logic [7:0] dat_w = '0, cnt_w;
  logic [1:0] dtc_w;
  logic       tc_w, bo_w, dn_w, le_w;

  // three digits mod 10,10,6
  logic        ld_3 = 0, en_3 = 0;
  logic [11:0] dat_3 = '0, cnt_3;
  logic [2:0]  dtc_3;
  logic        tc_3, bo_3, dn_3, le_3;

  contador_modn_cascata u_stop (
    .clk(clk), .clear(clear), .load(ld_a), .data(dat_a), .enable(en_a),
    .count(cnt_a), .digit_tc(dtc_a), .tc(tc_a), .borrow_out(bo_a),
    .done(dn_a), .load_err(le_a));

  contador_modn_cascata #(.STOP_AT_ZERO(0)) u_wrap (
    .clk(clk), .clear(clear), .load(ld_w), .data(dat_w), .enable(en_w),
    .count(cnt_w), .digit_tc(dtc_w), .tc(tc_w), .borrow_out(bo_w),
    .done(dn_w), .load_err(le_w));

  contador_modn_cascata #(.DIGITS(3), .MODS(12'h6AA)) u_d3 (
    .clk(clk), .clear(clear), .load(ld_3), .data(dat_3), .enable(en_3),
    .count(cnt_3), .digit_tc(dtc_3), .tc(tc_3), .borrow_out(bo_3),
    .done(dn_3), .load_err(le_3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 clear = 1'b0;
    #1;
    n_cmp++; if (cnt_a !== 8'h00) begin n_bad++; $display("FAIL rst_count got %h exp 00", cnt_a); end
    n_cmp++; if (tc_a !== 1'b1 || dtc_a !== 2'b11) begin n_bad++; $display("FAIL rst_tc got %b/%b exp 1/11", tc_a, dtc_a); end
    n_cmp++; if (dn_a !== 1'b0 || le_a !== 1'b0) begin n_bad++; $display("FAIL rst_pulses got %b/%b exp 0/0", dn_a, le_a); end
    n_cmp++; if (cnt_w !== 8'h00 || cnt_3 !== 12'h000) begin n_bad++; $display("FAIL rst_others got %h/%h exp 00/000", cnt_w, cnt_3); end
    tick();
    clear = 1'b1;
    // load 0x35, then clear asynchronously mid-count
    ld_a = 1; dat_a = 8'h35; tick();
    n_cmp++; if (cnt_a !== 8'h35) begin n_bad++; $display("FAIL rst_preload got %h exp 35", cnt_a); end
    ld_a = 0; en_a = 1; tick();
    n_cmp++; if (cnt_a !== 8'h34) begin n_bad++; $display("FAIL rst_predec got %h exp 34", cnt_a); end
    #2 clear = 1'b0;
    #1;
    n_cmp++; if (cnt_a !== 8'h00 || tc_a !== 1'b1 || dn_a !== 1'b0) begin n_bad++; $display("FAIL rst_async got %h tc %b done %b exp 00/1/0", cnt_a, tc_a, dn_a); end
    en_a = 0;
    tick();
    clear = 1'b1;
    tick(); tick();
    n_cmp++; if (cnt_a !== 8'h00) begin n_bad++; $display("FAIL rst_hold got %h exp 00", cnt_a); end
  endtask

  task automatic test_cascade();
    logic [7:0] exp_cnt;
    ld_a = 1; dat_a = 8'h10; tick();
    n_cmp++; if (cnt_a !== 8'h10 || le_a !== 1'b0) begin n_bad++; $display("FAIL casc_load got %h err %b exp 10/0", cnt_a, le_a); end
    ld_a = 0; en_a = 1;
    for (int k = 9; k >= 0; k--) begin
      tick();
      exp_cnt = 8'(k);
      n_cmp++; if (cnt_a !== exp_cnt) begin n_bad++; $display("FAIL casc_count got %h exp %h", cnt_a, exp_cnt); end
      n_cmp++; if (dn_a !== (k == 0)) begin n_bad++; $display("FAIL casc_done got %b exp %b at %h", dn_a, (k == 0), exp_cnt); end
      if (k == 9) begin
        n_cmp++; if (bo_a !== 1'b0) begin n_bad++; $display("FAIL casc_bo_nz got %b exp 0", bo_a); end
      end
    end
    tick();
    n_cmp++; if (cnt_a !== 8'h00 || dn_a !== 1'b0) begin n_bad++; $display("FAIL casc_stop got %h done %b exp 00/0", cnt_a, dn_a); end
    n_cmp++; if (bo_a !== 1'b1) begin n_bad++; $display("FAIL casc_bo got %b exp 1", bo_a); end
    en_a = 0;
    #1;
    n_cmp++; if (bo_a !== 1'b0) begin n_bad++; $display("FAIL casc_bo_off got %b exp 0", bo_a); end
  endtask

  task automatic test_wrap();
    ld_w = 1; dat_w = 8'h01; tick();
    ld_w = 0; en_w = 1; tick();
    n_cmp++; if (cnt_w !== 8'h00 || dn_w !== 1'b1) begin n_bad++; $display("FAIL wrap_zero got %h done %b exp 00/1", cnt_w, dn_w); end
    n_cmp++; if (bo_w !== 1'b1) begin n_bad++; $display("FAIL wrap_bo got %b exp 1", bo_w); end
    tick();
    n_cmp++; if (cnt_w !== 8'h59 || dn_w !== 1'b0) begin n_bad++; $display("FAIL wrap_max got %h done %b exp 59/0", cnt_w, dn_w); end
    n_cmp++; if (bo_w !== 1'b0) begin n_bad++; $display("FAIL wrap_bo_off got %b exp 0", bo_w); end
    tick();
    n_cmp++; if (cnt_w !== 8'h58) begin n_bad++; $display("FAIL wrap_next got %h exp 58", cnt_w); end
    en_w = 0;
  endtask

  task automatic test_load_sat();
    logic [7:0] din [5] = '{8'h7C, 8'h42, 8'h5C, 8'h69, 8'h59};
    logic [7:0] dexp[5] = '{8'h59, 8'h42, 8'h59, 8'h59, 8'h59};
    logic       eexp[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ld_a = 1;
    for (int i = 0; i < 5; i++) begin
      dat_a = din[i]; tick();
      n_cmp++; if (cnt_a !== dexp[i] || le_a !== eexp[i]) begin n_bad++; $display("FAIL sat_load data %h got %h err %b exp %h/%b", din[i], cnt_a, le_a, dexp[i], eexp[i]); end
    end
    dat_a = 8'h7C; tick();
    ld_a = 0; tick();
    n_cmp++; if (le_a !== 1'b0 || cnt_a !== 8'h59) begin n_bad++; $display("FAIL sat_pulse got err %b cnt %h exp 0/59", le_a, cnt_a); end
  endtask

  task automatic test_priority();
    ld_a = 1; en_a = 1; dat_a = 8'h25; tick();
    n_cmp++; if (cnt_a !== 8'h25 || dn_a !== 1'b0) begin n_bad++; $display("FAIL prio_load got %h done %b exp 25/0", cnt_a, dn_a); end
    ld_a = 0; en_a = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (cnt_a !== 8'h25 || dn_a !== 1'b0 || le_a !== 1'b0) begin n_bad++; $display("FAIL prio_pause got %h exp 25", cnt_a); end
    end
    ld_a = 1; en_a = 1; dat_a = 8'h00; tick();
    n_cmp++; if (cnt_a !== 8'h00 || tc_a !== 1'b1 || dn_a !== 1'b0) begin n_bad++; $display("FAIL prio_zero got %h tc %b done %b exp 00/1/0", cnt_a, tc_a, dn_a); end
    ld_a = 0; tick();
    n_cmp++; if (dn_a !== 1'b0 || cnt_a !== 8'h00) begin n_bad++; $display("FAIL prio_zero_en got %h done %b exp 00/0", cnt_a, dn_a); end
    en_a = 0;
  endtask

  task automatic test_sweep();
    ld_3 = 1; en_3 = 1; dat_3 = 12'h100; tick();
    n_cmp++; if (cnt_3 !== 12'h100 || dtc_3 !== 3'b011) begin n_bad++; $display("FAIL sweep_load got %h tc %b exp 100/011", cnt_3, dtc_3); end
    ld_3 = 0; tick();
    n_cmp++; if (cnt_3 !== 12'h099 || dtc_3 !== 3'b100) begin n_bad++; $display("FAIL sweep_step1 got %h tc %b exp 099/100", cnt_3, dtc_3); end
    tick();
    n_cmp++; if (cnt_3 !== 12'h098 || dtc_3 !== 3'b100) begin n_bad++; $display("FAIL sweep_step2 got %h tc %b exp 098/100", cnt_3, dtc_3); end
    ld_3 = 1; dat_3 = 12'hFAB; tick();
    n_cmp++; if (cnt_3 !== 12'h599 || le_3 !== 1'b1) begin n_bad++; $display("FAIL sweep_sat got %h err %b exp 599/1", cnt_3, le_3); end
    en_3 = 0; ld_3 = 0;
  endtask

  initial begin
    test_reset();
    test_cascade();
    test_wrap();
    test_load_sat();
    test_priority();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
